niosv_pio_ext: RTL

Parametrised general-purpose I/O peripheral on the Nios V Avalon-MM bus. Successor to the single-bit output PIO: generalised to WIDTH bits, with per-bit direction, atomic set/clear of the output register, synchronised inputs, edge capture and a maskable level interrupt. Sits between the Avalon-MM interconnect and board pins (LEDs, keys, switches, GPIO headers); the tristate buffers live in the top level, driven by out_port/oe.

---
 rtl/niosv_pio_ext_if.sv | 19 +
 rtl/niosv_pio_ext.sv | 122 ++++++++++++
 2 files changed

// File: rtl/niosv_pio_ext_if.sv
// Avalon-MM slave bus bundle for the extended PIO: register address, select,
// write strobe and the two data paths.
interface niosv_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niosv_pio_ext.sv
// WIDTH-bit general-purpose I/O on Avalon-MM: per-bit direction, atomic set/clear,
// synchronised inputs with edge capture, and a maskable registered level interrupt.
module niosv_pio_ext #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  niosv_pio_ext_if.slave       bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     oe,
  output logic                 irq
);

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

  logic [WIDTH-1:0]                  data_q, data_d;
  logic [WIDTH-1:0]                  dir_q, dir_d;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  cap_q, cap_d;
  logic [WIDTH-1:0]                  prev_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [2:0]                        prime_cnt_q, prime_cnt_d;
  logic                              primed_q, primed_d;
  logic                              irq_q, irq_d;

  logic                              wr_s;
  logic [WIDTH-1:0]                  wdata_s;
  logic [WIDTH-1:0]                  clr_s;
  logic [WIDTH-1:0]                  sync_in_s;
  logic [WIDTH-1:0]                  edge_s;
  logic [WIDTH-1:0]                  rd_bits_s;
  logic [31:0]                       rdata_s;
  logic                              unused_wdata_s;

  assign wr_s           = bus.chipselect & ~bus.write_n;
  assign wdata_s        = bus.writedata[WIDTH-1:0];
  assign unused_wdata_s = ^bus.writedata;
  assign sync_in_s      = sync_q[SYNC_STAGES-1];

  // Register write decode; an idle bus is steered to the ignored address 7.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr_s  = {WIDTH{1'b0}};
    case (wr_s ? bus.address : 3'd7)
      3'd0:    data_d = wdata_s;
      3'd1:    dir_d  = wdata_s;
      3'd2:    mask_d = wdata_s;
      3'd3:    clr_s  = wdata_s;
      3'd4:    data_d = data_q | wdata_s;
      3'd5:    data_d = data_q & ~wdata_s;
      default: clr_s  = {WIDTH{1'b0}};
    endcase
  end

  // Edge detector on the synchronised inputs, selected by EDGE_TYPE.
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      32'd0:   edge_s = sync_in_s & ~prev_q;
      32'd1:   edge_s = ~sync_in_s & prev_q;
      default: edge_s = sync_in_s ^ prev_q;
    endcase
  end

  // Capture (set beats clear), interrupt and priming next-state.
  always_comb begin
    cap_d       = (cap_q & ~clr_s) | (edge_s & {WIDTH{primed_q}});
    irq_d       = |(cap_q & mask_q);
    primed_d    = primed_q | (prime_cnt_q == PRIME_LAST);
    prime_cnt_d = primed_q ? prime_cnt_q : (prime_cnt_q + 3'd1);
  end

  // All state, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= RESET_VALUE;
      dir_q       <= {WIDTH{1'b0}};
      mask_q      <= {WIDTH{1'b0}};
      cap_q       <= {WIDTH{1'b0}};
      prev_q      <= {WIDTH{1'b0}};
      sync_q      <= '0;
      prime_cnt_q <= 3'd0;
      primed_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      data_q      <= data_d;
      dir_q       <= dir_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      prev_q      <= sync_in_s;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], in_port};
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      irq_q       <= irq_d;
    end
  end

  // Zero-wait-state read mux; DATA reflects the driven value on output bits.
  always_comb begin
    rd_bits_s = (data_q & dir_q) | (sync_in_s & ~dir_q);
    rdata_s   = 32'd0;
    case (bus.address)
      3'd0:    rdata_s[WIDTH-1:0] = rd_bits_s;
      3'd1:    rdata_s[WIDTH-1:0] = dir_q;
      3'd2:    rdata_s[WIDTH-1:0] = mask_q;
      3'd3:    rdata_s[WIDTH-1:0] = cap_q;
      default: rdata_s            = 32'd0;
    endcase
  end

  assign bus.readdata = rdata_s;
  assign out_port     = data_q;
  assign oe           = dir_q;
  assign irq          = irq_q;

endmodule
